// File: rtl/fifo_read_ctrl.sv
// fifo_read_ctrl: read-side controller of the async FIFO (r_clk domain).
// The RAM's registered read port is the output data stage; en_read only fires when that stage is free.
module fifo_read_ctrl #(
    parameter int ADDR_WIDTH = 4,
    parameter int RAM_HIGH   = 16,
    parameter int RAM_WIDTH  = 8,
    parameter int AE_LEVEL   = 2
) (
    input  logic                  r_clk,
    input  logic                  r_rst,
    input  logic [ADDR_WIDTH:0]   wptr_gray_sync,
    input  logic [RAM_WIDTH-1:0]  ram_r_data,
    output logic                  en_read,
    output logic [ADDR_WIDTH-1:0] r_addr,
    output logic [ADDR_WIDTH:0]   rptr_gray,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  m_valid,
    output logic [RAM_WIDTH-1:0]  m_data,
    input  logic                  m_ready
);
    localparam logic [ADDR_WIDTH:0] AE = AE_LEVEL[ADDR_WIDTH:0];
    logic [ADDR_WIDTH:0] rptr_bin, rptr_nxt, wptr_bin;
    if (RAM_HIGH != 2**ADDR_WIDTH) begin : g_bad_depth
        $error("RAM_HIGH must equal 2**ADDR_WIDTH");
    end
    always_comb begin
        wptr_bin = '0;
        wptr_bin[ADDR_WIDTH] = wptr_gray_sync[ADDR_WIDTH];
        for (int i = ADDR_WIDTH - 1; i >= 0; i--) wptr_bin[i] = wptr_bin[i+1] ^ wptr_gray_sync[i];
    end
    assign rptr_nxt     = rptr_bin + 1'b1;
    assign empty        = rptr_gray == wptr_gray_sync;
    assign level        = wptr_bin - rptr_bin;
    assign almost_empty = level <= AE;
    assign r_addr       = rptr_bin[ADDR_WIDTH-1:0];
    assign m_data       = ram_r_data;
    // Reset gating keeps the RAM idle while a (possibly lagging) write pointer still looks non-empty
    assign en_read      = !r_rst && !empty && (!m_valid || m_ready);
    always_ff @(posedge r_clk or posedge r_rst) begin
        if (r_rst) begin
            rptr_bin  <= '0;
            rptr_gray <= '0;
            m_valid   <= 1'b0;
        end else begin
            if (en_read) begin
                rptr_bin  <= rptr_nxt;
                rptr_gray <= rptr_nxt ^ (rptr_nxt >> 1);
            end
            m_valid <= en_read ? 1'b1 : m_ready ? 1'b0 : m_valid;
        end
    end
endmodule

// File: tb/tb_fifo_read_ctrl.sv
// tb_fifo_read_ctrl: bench with a RAM/write-side model and an in-order scoreboard of written words.
module tb_fifo_read_ctrl;
    logic       r_clk = 1'b0;
    logic       r_rst, en_read, empty, almost_empty, m_valid, m_ready;
    logic [4:0] wptr_gray_sync, rptr_gray, level, wbin, exp_rptr, prev_g;
    logic [3:0] r_addr;
    logic [7:0] ram_r_data, m_data;
    logic [7:0] mem [16];
    logic [7:0] q [$];
    logic       mon, exp_mv, saw_wrap;
    int         tests = 0, fails = 0;

    fifo_read_ctrl dut (
        .r_clk(r_clk), .r_rst(r_rst), .wptr_gray_sync(wptr_gray_sync), .ram_r_data(ram_r_data),
        .en_read(en_read), .r_addr(r_addr), .rptr_gray(rptr_gray), .empty(empty),
        .almost_empty(almost_empty), .level(level), .m_valid(m_valid), .m_data(m_data),
        .m_ready(m_ready)
    );

    always #5 r_clk = ~r_clk;
    assign wptr_gray_sync = wbin ^ (wbin >> 1);
    always @(posedge r_clk) if (en_read) ram_r_data <= mem[r_addr];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic step;
        @(posedge r_clk);
        #1;
    endtask

    task automatic wr;
        logic [7:0] d;
        d = 8'($urandom);
        mem[wbin[3:0]] = d;
        q.push_back(d);
        wbin++;
    endtask

    // Reference model checked every cycle: pointer, level flags, read issue, valid and data order
    always @(negedge r_clk) begin : monitor
        logic [4:0] lv;
        logic       exp_en;
        if (mon && !r_rst) begin
            lv     = wbin - exp_rptr;
            exp_en = (lv != 0) && (!exp_mv || m_ready);
            chk("rptr_gray", rptr_gray, exp_rptr ^ (exp_rptr >> 1));
            chk("level", level, lv);
            chk("empty", empty, lv == 0);
            chk("almost_empty", almost_empty, lv <= 2);
            chk("en_read", en_read, exp_en);
            chk("m_valid", m_valid, exp_mv);
            if (exp_en) chk("r_addr", r_addr, exp_rptr[3:0]);
            if (m_valid) begin
                if (q.size() == 0) chk("sb_underflow", 1, 0);
                else begin
                    chk("m_data", m_data, q[0]);
                    if (m_ready) void'(q.pop_front());
                end
            end
            if (prev_g == 5'b10000 && rptr_gray == 5'b00000) saw_wrap = 1'b1;
            prev_g = rptr_gray;
            if (exp_en) exp_rptr++;
            exp_mv = exp_en ? 1'b1 : m_ready ? 1'b0 : exp_mv;
        end
    end

    initial begin
        logic [7:0] d0;
        int n;
        r_rst = 1'b1; wbin = '0; m_ready = 1'b0; mon = 1'b0;
        exp_rptr = '0; exp_mv = 1'b0; saw_wrap = 1'b0; prev_g = '0;
        step; step;
        chk("rst_rptr_gray", rptr_gray, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_en_read", en_read, 0);
        chk("rst_empty", empty, 1);
        chk("rst_level", level, 0);
        chk("rst_ae", almost_empty, 1);
        r_rst = 1'b0; mon = 1'b1;
        step;
        // single word
        wr; d0 = q[0]; #1;
        chk("single_en", en_read, 1);
        chk("single_addr", r_addr, 0);
        step;
        chk("single_valid", m_valid, 1);
        chk("single_data", m_data, d0);
        chk("single_gray", rptr_gray, 1);
        chk("single_empty", empty, 1);
        // backpressure with 3 words available
        wr; wr;
        repeat (5) begin
            step;
            chk("bp_en", en_read, 0);
            chk("bp_data", m_data, d0);
            chk("bp_gray", rptr_gray, 1);
        end
        m_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("bp_acc_valid", m_valid, 1);
            step;
        end
        chk("bp_drained", q.size(), 0);
        chk("bp_valid_low", m_valid, 0);
        // burst of a full FIFO
        repeat (16) wr;
        #1;
        chk("burst_full", level, 16);
        for (int i = 0; i < 16; i++) begin
            chk("burst_en", en_read, 1);
            chk("burst_level", level, 16 - i);
            chk("burst_ae", almost_empty, (16 - i) <= 2);
            step;
        end
        chk("burst_en_end", en_read, 0);
        chk("burst_empty", empty, 1);
        step;
        chk("burst_drained", q.size(), 0);
        // wrap-around with random consumer
        n = 0;
        for (int c = 0; c < 2000 && (n < 40 || q.size() != 0); c++) begin
            m_ready = 1'($urandom);
            if (n < 40 && 5'(wbin - exp_rptr) < 16 && $urandom_range(0, 2) != 0) begin
                wr;
                n++;
            end
            step;
        end
        chk("wrap_written", n, 40);
        chk("wrap_drained", q.size(), 0);
        chk("wrap_seen", saw_wrap, 1);
        // reset mid-stream
        m_ready = 1'b1;
        repeat (4) step;
        m_ready = 1'b0;
        repeat (6) wr;
        step;
        chk("mid_level", level, 5);
        chk("mid_valid", m_valid, 1);
        #2;
        mon = 1'b0; r_rst = 1'b1;
        #1;
        chk("arst_valid", m_valid, 0);
        chk("arst_gray", rptr_gray, 0);
        chk("arst_en", en_read, 0);
        repeat (2) begin
            step;
            chk("rst_hold_en", en_read, 0);
        end
        wbin = '0; q.delete(); exp_rptr = '0; exp_mv = 1'b0; prev_g = '0;
        step;
        r_rst = 1'b0; mon = 1'b1;
        #1;
        chk("post_rst_empty", empty, 1);
        chk("post_rst_en", en_read, 0);
        m_ready = 1'b1;
        wr;
        repeat (3) step;
        chk("post_rst_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
